// File: rtl/snake_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : snake_score_keeper
//  Description : Score register and game-state tracker for Scream-at-Snake.
//                Counts food events during play and saturates at MAX_SCORE.
//                Keeps the session high score and runs the
//                IDLE / PLAYING / GAME_OVER state machine. Requests a digit
//                blink (blank) while a new high score is shown.
//  Ports       : clk, resetn (async, active-low)
//                start, food_eaten, collision  - level inputs
//                score_output[7:0], high_score[7:0], new_high, blank,
//                state[1:0] (00 IDLE, 01 PLAYING, 10 GAME_OVER)
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_score_keeper #(
    parameter int MAX_SCORE    = 250,
    parameter int FLASH_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       food_eaten,
    input  logic       collision,
    output logic [7:0] score_output,
    output logic [7:0] high_score,
    output logic       new_high,
    output logic       blank,
    output logic [1:0] state
);

    localparam logic [1:0] c_ST_IDLE      = 2'b00;
    localparam logic [1:0] c_ST_PLAYING   = 2'b01;
    localparam logic [1:0] c_ST_GAME_OVER = 2'b10;

    localparam int                 c_CNT_W     = (FLASH_CYCLES > 2) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(FLASH_CYCLES - 1);
    localparam logic [7:0]         c_MAX_SCORE = 8'(MAX_SCORE);

    logic [1:0]         r_state;
    logic [7:0]         r_score;
    logic [7:0]         r_high;
    logic               r_new_high;
    logic               r_blank;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_start_prev;
    logic               r_food_prev;

    logic               w_start_rise;
    logic               w_food_rise;
    logic [1:0]         w_state_nxt;
    logic [7:0]         w_score_nxt;
    logic [7:0]         w_high_nxt;
    logic               w_new_high_nxt;
    logic               w_blank_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    // The edge-detect history flops reset to 1, so a level already high when
    // reset is released does not count as an event.
    assign w_start_rise = start      & ~r_start_prev;
    assign w_food_rise  = food_eaten & ~r_food_prev;

    always_comb begin
        w_state_nxt    = r_state;
        w_score_nxt    = r_score;
        w_high_nxt     = r_high;
        w_new_high_nxt = r_new_high;
        // Blank and the flash counter are held at zero unless flashing.
        w_blank_nxt    = 1'b0;
        w_cnt_nxt      = '0;

        case (r_state)
            c_ST_IDLE: begin
                w_score_nxt = 8'd0;
                if (w_start_rise) begin
                    w_state_nxt = c_ST_PLAYING;
                end
            end

            c_ST_PLAYING: begin
                // Collision wins over a simultaneous food edge.
                if (collision) begin
                    w_state_nxt = c_ST_GAME_OVER;
                    if (r_score > r_high) begin
                        w_high_nxt     = r_score;
                        w_new_high_nxt = 1'b1;
                    end else begin
                        w_new_high_nxt = 1'b0;
                    end
                end else if (w_food_rise && (r_score < c_MAX_SCORE)) begin
                    w_score_nxt = r_score + 8'd1;
                end
            end

            c_ST_GAME_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt    = c_ST_PLAYING;
                    w_score_nxt    = 8'd0;
                    w_new_high_nxt = 1'b0;
                end else if (r_new_high) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_blank_nxt = ~r_blank;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_blank_nxt = r_blank;
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle.
                w_state_nxt    = c_ST_IDLE;
                w_score_nxt    = 8'd0;
                w_new_high_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_ST_IDLE;
            r_score      <= 8'd0;
            r_high       <= 8'd0;
            r_new_high   <= 1'b0;
            r_blank      <= 1'b0;
            r_cnt        <= '0;
            r_start_prev <= 1'b1;
            r_food_prev  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_score      <= w_score_nxt;
            r_high       <= w_high_nxt;
            r_new_high   <= w_new_high_nxt;
            r_blank      <= w_blank_nxt;
            r_cnt        <= w_cnt_nxt;
            r_start_prev <= start;
            r_food_prev  <= food_eaten;
        end
    end

    assign score_output = r_score;
    assign high_score   = r_high;
    assign new_high     = r_new_high;
    assign blank        = r_blank;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_snake_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_score_keeper
//  Description : Directed self-checking bench for snake_score_keeper. One
//                instance uses MAX_SCORE=250, a second uses MAX_SCORE=5 for
//                saturation; both use FLASH_CYCLES=4. Expected outputs are
//                queued when stimulus is driven and compared once the DUT
//                has had its clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_score_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       start, food_eaten, collision;
    logic       s_start, s_food, s_coll;

    logic [7:0] m_score, m_high, s_score, s_high;
    logic       m_new, m_blank, s_new, s_blank;
    logic [1:0] m_state, s_state;

    snake_score_keeper #(.MAX_SCORE(250), .FLASH_CYCLES(4)) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .food_eaten   (food_eaten),
        .collision    (collision),
        .score_output (m_score),
        .high_score   (m_high),
        .new_high     (m_new),
        .blank        (m_blank),
        .state        (m_state)
    );

    snake_score_keeper #(.MAX_SCORE(5), .FLASH_CYCLES(4)) u_dut_sat (
        .clk          (clk),
        .resetn       (resetn),
        .start        (s_start),
        .food_eaten   (s_food),
        .collision    (s_coll),
        .score_output (s_score),
        .high_score   (s_high),
        .new_high     (s_new),
        .blank        (s_blank),
        .state        (s_state)
    );

    typedef struct {
        string      tag;
        bit         unit;   // 0: main instance, 1: saturating instance
        logic [1:0] st;
        logic [7:0] sc;
        logic [7:0] hi;
        logic       nh;
        logic       bl;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pending();
        exp_t       e;
        logic [1:0] o_st;
        logic [7:0] o_sc, o_hi;
        logic       o_nh, o_bl;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.unit) begin
                o_st = s_state; o_sc = s_score; o_hi = s_high; o_nh = s_new; o_bl = s_blank;
            end else begin
                o_st = m_state; o_sc = m_score; o_hi = m_high; o_nh = m_new; o_bl = m_blank;
            end
            chk({e.tag, ".state"},    32'(o_st), 32'(e.st));
            chk({e.tag, ".score"},    32'(o_sc), 32'(e.sc));
            chk({e.tag, ".high"},     32'(o_hi), 32'(e.hi));
            chk({e.tag, ".new_high"}, 32'(o_nh), 32'(e.nh));
            chk({e.tag, ".blank"},    32'(o_bl), 32'(e.bl));
        end
    endtask

    task automatic exp_m(input string tag, input logic [1:0] st, input logic [7:0] sc,
                         input logic [7:0] hi, input logic nh, input logic bl);
        exp_t e;
        e.tag = tag; e.unit = 1'b0; e.st = st; e.sc = sc; e.hi = hi; e.nh = nh; e.bl = bl;
        q.push_back(e);
    endtask

    task automatic exp_s(input string tag, input logic [1:0] st, input logic [7:0] sc,
                         input logic [7:0] hi, input logic nh, input logic bl);
        exp_t e;
        e.tag = tag; e.unit = 1'b1; e.st = st; e.sc = sc; e.hi = hi; e.nh = nh; e.bl = bl;
        q.push_back(e);
    endtask

    task automatic drive(input logic st, input logic fd, input logic co);
        start = st; food_eaten = fd; collision = co;
    endtask

    task automatic sdrive(input logic st, input logic fd, input logic co);
        s_start = st; s_food = fd; s_coll = co;
    endtask

    // Advance one clock and compare everything queued for that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check_pending();
    endtask

    task automatic new_game(input string tag, input logic [7:0] hi);
        drive(1'b1, 1'b0, 1'b0);
        exp_m(tag, 2'b01, 8'd0, hi, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic play(input string tag, input int n, input logic [7:0] hi);
        for (int p = 1; p <= n; p++) begin
            drive(1'b0, 1'b1, 1'b0);
            exp_m(tag, 2'b01, 8'(p), hi, 1'b0, 1'b0);
            tick();
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    logic bexp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        resetn = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        sdrive(1'b0, 1'b0, 1'b0);
        #1;
        exp_m("reset", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
        exp_s("reset_sat", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
        check_pending();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // start held high through reset release is not an event
        for (int i = 0; i < 3; i++) begin
            exp_m("start_held", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0);
        exp_m("start_pulse", 2'b01, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();

        // food held for 10 cycles counts once, then three pulses
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_m("food_held", 2'b01, 8'd1, 8'd0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        tick();
        for (int p = 2; p <= 4; p++) begin
            drive(1'b0, 1'b1, 1'b0);
            exp_m("food_pulse", 2'b01, 8'(p), 8'd0, 1'b0, 1'b0);
            tick();
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end

        // start edge while playing is ignored
        drive(1'b1, 1'b0, 1'b0);
        exp_m("start_in_play", 2'b01, 8'd4, 8'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();

        // game over with a new high; flash sequence, food/collision ignored
        drive(1'b0, 1'b0, 1'b1);
        exp_m("g1_over", 2'b10, 8'd4, 8'd4, 1'b1, 1'b0);
        tick();
        for (int i = 2; i <= 9; i++) begin
            drive(1'b0, 1'(i % 2), 1'b1);
            exp_m("flash", 2'b10, 8'd4, 8'd4, 1'b1, bexp[i-2]);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 10; i <= 13; i++) begin
            exp_m("flash2", 2'b10, 8'd4, 8'd4, 1'b1, 1'(i == 13));
            tick();
        end

        // restart mid-flash (blank currently high)
        new_game("restart", 8'd4);

        // game 2 ends at 7: new high
        play("g2", 7, 8'd4);
        drive(1'b0, 1'b0, 1'b1);
        exp_m("g2_over", 2'b10, 8'd7, 8'd7, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();

        // game 3 ties at 7: no new high, no flash
        new_game("g3_start", 8'd7);
        play("g3", 7, 8'd7);
        drive(1'b0, 1'b0, 1'b1);
        exp_m("g3_tie", 2'b10, 8'd7, 8'd7, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            exp_m("tie_noflash", 2'b10, 8'd7, 8'd7, 1'b0, 1'b0);
            tick();
        end

        // game 4 ends lower: high score kept
        new_game("g4_start", 8'd7);
        play("g4", 3, 8'd7);
        drive(1'b0, 1'b0, 1'b1);
        exp_m("g4_low", 2'b10, 8'd3, 8'd7, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();

        // game 5: collision with a simultaneous food edge at score 2
        new_game("g5_start", 8'd7);
        play("g5", 2, 8'd7);
        drive(1'b0, 1'b1, 1'b1);
        exp_m("coll_food", 2'b10, 8'd2, 8'd7, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();

        // saturation at MAX_SCORE=5
        sdrive(1'b1, 1'b0, 1'b0);
        exp_s("sat_start", 2'b01, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        sdrive(1'b0, 1'b0, 1'b0);
        tick();
        for (int p = 1; p <= 8; p++) begin
            sdrive(1'b0, 1'b1, 1'b0);
            exp_s("sat_food", 2'b01, (p > 5) ? 8'd5 : 8'(p), 8'd0, 1'b0, 1'b0);
            tick();
            sdrive(1'b0, 1'b0, 1'b0);
            tick();
        end
        sdrive(1'b0, 1'b0, 1'b1);
        exp_s("sat_over", 2'b10, 8'd5, 8'd5, 1'b1, 1'b0);
        exp_m("main_idle_go", 2'b10, 8'd2, 8'd7, 1'b0, 1'b0);
        tick();
        sdrive(1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            exp_s("sat_flash", 2'b10, 8'd5, 8'd5, 1'b1, 1'(i == 5));
            tick();
        end

        // asynchronous reset mid-flash, checked before any clock edge
        #3;
        resetn = 1'b0;
        #1;
        exp_m("async_rst", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
        exp_s("async_rst_sat", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
        check_pending();
        #3;
        resetn = 1'b1;
        exp_m("post_rst", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
        exp_s("post_rst_sat", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
